systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Operand transmitter for one edge of an N-lane systolic PE array. It drives either the left inputs of the array's rows or the up inputs of its columns.
- Accepts K operand vectors over a valid/ready stream and buffers them. It then issues a one-cycle PE clear, followed by the vectors, diagonally skewed so that lane i lags by i cycles.
- Zero padding follows the data so the last products propagate through the array. One feeder instance is used per array edge; both are started together.

Parameters:
- N, 4, number of lanes (array rows or columns)
- K_MAX, 16, maximum vectors per job (buffer depth)
- DW, 8, operand width per lane

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  $clog2(K_MAX+1)  vectors in this job; latched on accepted start
- s_valid  in  1  operand vector valid
- s_ready  out  1  feeder can accept a vector
- s_data  in  N*DW  operand vector; lane i = s_data[i*DW +: DW]
- lane_out  out  N*DW  skewed operands to the PE edge; lane i = lane_out[i*DW +: DW]
- pe_clear  out  1  drives the PE in_valid (accumulator/pipeline clear)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async, rst=1): state IDLE; lane_out=0, pe_clear=0, s_ready=0, busy=0, done=0; counters=0. Buffer contents are don't-care.
- All outputs are registered.
- States: IDLE -> LOAD -> CLEAR -> STREAM -> DONE -> IDLE.
- IDLE:
  - start=1 latches klen = min(k_len, K_MAX).
  - If klen==0, go to DONE directly (no clear, no stream).
  - Otherwise go to LOAD; s_ready=1 from the next cycle.
- LOAD:
  - Each cycle with s_valid&&s_ready writes buf[wptr]=s_data, then wptr++.
  - On the klen-th handshake, s_ready drops to 0 in the next cycle and the state becomes CLEAR.
  - No handshake is accepted beyond klen.
  - s_valid low stalls LOAD indefinitely.
- CLEAR: exactly one cycle with pe_clear=1 and lane_out=0, then STREAM with t=0.
- STREAM: lasts klen+2N-2 cycles, t=0..klen+2N-3.
  - lane_out lane i = buf[t-i][i] when 0 <= t-i < klen, else 0.
  - pe_clear=0 throughout.
  - The trailing zeros give N-1 cycles of skew padding plus N-1 cycles of array propagation. Zeros add nothing to PE accumulators.
- DONE: done=1 for one cycle, lane_out=0, then IDLE.
- start outside IDLE is ignored; k_len is not re-sampled mid-job.
- start and s_valid in the same IDLE cycle: the vector is not accepted (s_ready=0 in IDLE).
- rst mid-operation: immediate return to IDLE with all outputs zero; a partial job is discarded and no done is issued.
- Widths: t and the stream counter are sized for K_MAX+2N-2. wptr is $clog2(K_MAX) bits and never wraps within a job.

Decomposition:
- Package systolic_pkg holds:
  - the state enum: IDLE, LOAD, CLEAR, STREAM, DONE
  - DW and lane-slice helper constants, shared with the PE array top
- Sub-module feeder_buf:
  - K_MAX x (N*DW) register array
  - one write port (we, waddr, wdata)
  - N independent read ports; read port i is addressed per cycle with lane i of its row
  - reads are combinational; the registering is done in systolic_feeder

Test Plan:
- N=4, k_len=2, vectors v0=0x04030201, v1=0x08070605:
  - one pe_clear cycle, then 8 STREAM cycles.
  - lane0 = 01,05,0,0,0,0,0,0
  - lane1 = 0,02,06,0,...
  - lane3 = 0,0,0,04,08,0,0,0
  - then a done pulse.
- k_len=0 start:
  - done one cycle after start; pe_clear never asserts; s_ready stays 0.
- k_len=3 with s_valid toggling 1,0,1,0,1:
  - exactly 3 handshakes; s_ready drops after the third.
  - stream matches the 3 vectors; a 4th offered vector is not consumed.
- k_len=20 (greater than K_MAX=16):
  - 16 handshakes accepted; STREAM lasts 22 cycles.
- start pulsed during STREAM: no effect; the job completes with a single done.
- rst asserted at STREAM t=2:
  - outputs zero immediately; busy=0; no done.
  - a new job with k_len=1, v0=0x11223344 then runs correctly (lane0=0x44 at t=0, lane3=0x11 at t=3).

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// systolic_pkg: shared state encoding and lane geometry for the feeder and PE array top
package systolic_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_K_MAX = 16;
    localparam int DEF_DW    = 8;

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, DONE} state_t;

    // Low bit of lane `lane` inside a packed N*dw operand vector
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: valid/ready operand-vector stream into the feeder
interface systolic_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 8
) ();

    logic            valid;
    logic            ready;
    logic [N*DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/systolic_feeder_buf.sv
// feeder_buf: K_MAX-row operand store, one row write port, one combinational read port per lane
module feeder_buf
    import systolic_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int K_MAX = DEF_K_MAX,
    parameter int DW    = DEF_DW
) (
    input  logic                                clk,
    input  logic                                i_we,
    input  logic [$clog2(K_MAX)-1:0]            i_waddr,
    input  logic [N*DW-1:0]                     i_wdata,
    input  logic [N-1:0][$clog2(K_MAX)-1:0]     i_raddr,
    output logic [N-1:0][DW-1:0]                o_rdata
);

    logic [N*DW-1:0] r_mem [K_MAX];

    // Contents are don't-care until written, so the array carries no reset
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Each lane reads its own slice from its own row, giving the diagonal skew
    for (genvar g = 0; g < N; g++) begin : g_rd
        assign o_rdata[g] = r_mem[i_raddr[g]][lane_lo(g, DW) +: DW];
    end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers K operand vectors, then emits a PE clear and a diagonally skewed stream
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int K_MAX = DEF_K_MAX,
    parameter int DW    = DEF_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [$clog2(K_MAX+1)-1:0] i_k_len,
    systolic_feeder_if.slave           sif,
    output logic [N*DW-1:0]            o_lane_out,
    output logic                       o_pe_clear,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int AW = $clog2(K_MAX);
    localparam int TW = $clog2(K_MAX + 2 * N - 1);

    state_t                   r_state, w_next;
    logic [KW-1:0]            r_klen;
    logic [KW-1:0]            w_klen_in;
    logic [AW-1:0]            r_wptr;
    logic [TW-1:0]            r_t, w_t;
    logic [TW-1:0]            w_tend;
    logic                     w_we, w_last;
    logic                     r_ready, r_pe_clear, r_busy, r_done;
    logic [N*DW-1:0]          r_lane;
    logic [N-1:0][AW-1:0]     w_raddr;
    logic [N-1:0][DW-1:0]     w_rdata;
    logic [N-1:0][DW-1:0]     w_lane;

    assign w_klen_in = (i_k_len > KW'(K_MAX)) ? KW'(K_MAX) : i_k_len;
    assign w_we      = (r_state == LOAD) && sif.valid && r_ready;
    assign w_last    = w_we && (KW'(r_wptr) + KW'(1) == r_klen);
    assign w_tend    = TW'(r_klen) + TW'(2 * N - 3);

    // Next state and stream index; outputs are registered from the upcoming state
    always_comb begin
        w_next = r_state;
        w_t    = r_t;
        case (r_state)
            IDLE:    if (i_start) w_next = (w_klen_in == '0) ? DONE : LOAD;
            LOAD:    if (w_last) w_next = CLEAR;
            CLEAR: begin
                w_next = STREAM;
                w_t    = '0;
            end
            STREAM: begin
                w_next = (r_t == w_tend) ? DONE : STREAM;
                w_t    = (r_t == w_tend) ? r_t : r_t + TW'(1);
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    feeder_buf #(.N(N), .K_MAX(K_MAX), .DW(DW)) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (sif.data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Lane i shows row t-i only while that row exists; otherwise it pads with zero
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign w_raddr[g] = AW'(w_t - TW'(g));
        assign w_lane[g]  = (w_next == STREAM && w_t >= TW'(g) && (w_t - TW'(g)) < TW'(r_klen))
                            ? w_rdata[g] : '0;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_klen     <= '0;
            r_wptr     <= '0;
            r_t        <= '0;
            r_ready    <= 1'b0;
            r_pe_clear <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lane     <= '0;
        end else begin
            r_state    <= w_next;
            r_klen     <= (r_state == IDLE && i_start) ? w_klen_in : r_klen;
            r_wptr     <= (r_state == IDLE) ? '0 : (w_we && !w_last) ? r_wptr + AW'(1) : r_wptr;
            r_t        <= w_t;
            r_ready    <= (w_next == LOAD);
            r_pe_clear <= (w_next == CLEAR);
            r_busy     <= (w_next != IDLE);
            r_done     <= (w_next == DONE);
            r_lane     <= w_lane;
        end
    end

    assign sif.ready  = r_ready;
    assign o_lane_out = r_lane;
    assign o_pe_clear = r_pe_clear;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized jobs checked against a skew/padding reference model
module tb_systolic_feeder;

    localparam int N      = 4;
    localparam int K_MAX  = 16;
    localparam int DW     = 8;
    localparam int KW     = $clog2(K_MAX + 1);
    localparam int VW     = N * DW;
    localparam int BUDGET = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [KW-1:0] i_k_len = '0;
    logic [VW-1:0] o_lane_out;
    logic          o_pe_clear, o_busy, o_done;

    systolic_feeder_if #(.N(N), .DW(DW)) sif ();

    systolic_feeder #(.N(N), .K_MAX(K_MAX), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_k_len    (i_k_len),
        .sif        (sif),
        .o_lane_out (o_lane_out),
        .o_pe_clear (o_pe_clear),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [VW-1:0] vecs[$];
    logic [VW-1:0] cap_lane[BUDGET];
    logic          cap_done[BUDGET];
    int cap_n, cap_ci, cap_di, cap_nclr, cap_nready, hs;

    // Expected edge vector at stream cycle t: lane i carries row t-i when that row exists
    function automatic logic [VW-1:0] model_row(input int t, input int kl);
        logic [VW-1:0] r;
        logic [VW-1:0] v;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < kl) begin
                v = vecs[t-i];
                r[i*DW +: DW] = v[i*DW +: DW];
            end
        end
        return r;
    endfunction

    // Start a job, feed vecs with a valid pattern, record outputs each cycle until done
    task automatic run_job(input int kreq, input int pat, input int extra_start);
        logic v;
        @(negedge clk);
        i_start = 1'b1;
        i_k_len = KW'(kreq);
        sif.valid = 1'b0;
        cap_n = 0; hs = 0; cap_ci = -1; cap_di = -1; cap_nclr = 0; cap_nready = 0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            i_start = (c == extra_start);
            cap_lane[c] = o_lane_out;
            cap_done[c] = o_done;
            cap_n = c + 1;
            if (o_pe_clear) begin
                cap_nclr++;
                if (cap_ci < 0) cap_ci = c;
            end
            if (sif.ready) cap_nready++;
            if (o_done) begin
                cap_di = c;
                break;
            end
            v = (hs < vecs.size()) && (pat == 0 ? 1'b1 : pat == 1 ? (c % 2 == 0) : ($urandom_range(0, 3) != 0));
            sif.valid = v;
            sif.data  = v ? vecs[hs] : '0;
            if (v && sif.ready) hs++;
        end
        i_start = 1'b0;
        sif.valid = 1'b0;
    endtask

    task automatic test_reset();
        sif.valid = 1'b0;
        sif.data  = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({o_lane_out, o_pe_clear, o_busy, o_done, sif.ready} !== '0)
            $display("FAIL reset_outputs got lane=%h clr=%b busy=%b done=%b rdy=%b exp all zero",
                     o_lane_out, o_pe_clear, o_busy, o_done, sif.ready);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (o_busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", o_busy); else n_pass++;
    endtask

    task automatic test_basic();
        vecs = {32'h04030201, 32'h08070605};
        run_job(2, 0, -1);
        n_total++;
        if (cap_ci !== 2 || cap_nclr !== 1) $display("FAIL basic_clear got idx=%0d n=%0d exp idx=2 n=1", cap_ci, cap_nclr); else n_pass++;
        n_total++;
        if (cap_lane[cap_ci] !== '0) $display("FAIL basic_clear_lane got %h exp 0", cap_lane[cap_ci]); else n_pass++;
        for (int t = 0; t < 2 + 2 * N - 2; t++) begin
            n_total++;
            if (cap_lane[cap_ci+1+t] !== model_row(t, 2))
                $display("FAIL basic_stream t=%0d got %h exp %h", t, cap_lane[cap_ci+1+t], model_row(t, 2));
            else n_pass++;
        end
        n_total++;
        if (cap_lane[3][7:0] !== 8'h01 || cap_lane[4][7:0] !== 8'h05 || cap_lane[6][31:24] !== 8'h04 || cap_lane[7][31:24] !== 8'h08)
            $display("FAIL basic_spots got %h %h %h %h exp 01 05 04 08",
                     cap_lane[3][7:0], cap_lane[4][7:0], cap_lane[6][31:24], cap_lane[7][31:24]);
        else n_pass++;
        n_total++;
        if (cap_di !== 11) $display("FAIL basic_done_idx got %0d exp 11", cap_di); else n_pass++;
    endtask

    task automatic test_zero_len();
        vecs = {32'hdeadbeef};
        run_job(0, 0, -1);
        n_total++;
        if (cap_di !== 0 || cap_nclr !== 0 || cap_nready !== 0 || hs !== 0)
            $display("FAIL zero_len got done_idx=%0d clears=%0d ready=%0d hs=%0d exp 0 0 0 0", cap_di, cap_nclr, cap_nready, hs);
        else n_pass++;
    endtask

    task automatic test_stall();
        vecs.delete();
        for (int i = 0; i < 4; i++) vecs.push_back(VW'($urandom));
        run_job(3, 1, -1);
        n_total++;
        if (hs !== 3 || cap_ci !== 5) $display("FAIL stall_hs got hs=%0d clear_idx=%0d exp 3 5", hs, cap_ci); else n_pass++;
        for (int t = 0; t < 3 + 2 * N - 2; t++) begin
            n_total++;
            if (cap_lane[cap_ci+1+t] !== model_row(t, 3))
                $display("FAIL stall_stream t=%0d got %h exp %h", t, cap_lane[cap_ci+1+t], model_row(t, 3));
            else n_pass++;
        end
        n_total++;
        if (cap_di !== cap_ci + 3 + 2 * N - 1) $display("FAIL stall_done_idx got %0d exp %0d", cap_di, cap_ci + 3 + 2 * N - 1); else n_pass++;
    endtask

    task automatic test_overlen();
        vecs.delete();
        for (int i = 0; i < 20; i++) vecs.push_back(VW'($urandom));
        run_job(20, 0, -1);
        n_total++;
        if (hs !== K_MAX || cap_nready !== K_MAX) $display("FAIL overlen_hs got hs=%0d ready=%0d exp 16", hs, cap_nready); else n_pass++;
        n_total++;
        if (cap_di - cap_ci - 1 !== 22 || cap_ci < 0) $display("FAIL overlen_len got %0d exp 22", cap_di - cap_ci - 1); else n_pass++;
        for (int t = 0; t < K_MAX + 2 * N - 2; t++) begin
            n_total++;
            if (cap_lane[cap_ci+1+t] !== model_row(t, K_MAX))
                $display("FAIL overlen_stream t=%0d got %h exp %h", t, cap_lane[cap_ci+1+t], model_row(t, K_MAX));
            else n_pass++;
        end
    endtask

    task automatic test_start_during_stream();
        int k, extra;
        k = $urandom_range(1, 4);
        vecs.delete();
        for (int i = 0; i < k; i++) vecs.push_back(VW'($urandom));
        run_job(k, 0, k + 4);
        n_total++;
        if (cap_di !== k + 2 * N - 1 + k) $display("FAIL restart_done_idx got %0d exp %0d", cap_di, 2 * k + 2 * N - 1); else n_pass++;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done || o_busy) extra++;
        end
        n_total++;
        if (extra !== 0) $display("FAIL restart_extra got %0d busy/done cycles exp 0", extra); else n_pass++;
    endtask

    task automatic test_rst_mid();
        int ci, hits;
        ci = -1;
        vecs.delete();
        for (int i = 0; i < 3; i++) vecs.push_back(VW'($urandom));
        @(negedge clk);
        i_start = 1'b1;
        i_k_len = KW'(3);
        hs = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_pe_clear) ci = c;
            if (ci >= 0 && c == ci + 3) break;
            sif.valid = (hs < 3);
            sif.data  = vecs[hs < 3 ? hs : 0];
            if (sif.valid && sif.ready) hs++;
        end
        sif.valid = 1'b0;
        n_total++;
        if (ci < 0) $display("FAIL rst_mid_reach got no clear exp clear"); else n_pass++;
        n_total++;
        if (o_lane_out !== model_row(2, 3)) $display("FAIL rst_mid_pre got %h exp %h", o_lane_out, model_row(2, 3)); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({o_lane_out, o_pe_clear, o_busy, o_done, sif.ready} !== '0)
            $display("FAIL rst_mid_outputs got lane=%h clr=%b busy=%b done=%b exp all zero", o_lane_out, o_pe_clear, o_busy, o_done);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done || o_busy) hits++;
        end
        n_total++;
        if (hits !== 0) $display("FAIL rst_mid_no_done got %0d busy/done cycles exp 0", hits); else n_pass++;
        vecs = {32'h11223344};
        run_job(1, 0, -1);
        n_total++;
        if (cap_ci < 0 || cap_lane[cap_ci+1][7:0] !== 8'h44 || cap_lane[cap_ci+4][31:24] !== 8'h11)
            $display("FAIL rst_mid_rerun got %h %h exp 44 11", cap_lane[cap_ci+1][7:0], cap_lane[cap_ci+4][31:24]);
        else n_pass++;
        n_total++;
        if (cap_di !== cap_ci + 1 + 2 * N - 1) $display("FAIL rst_mid_rerun_done got %0d exp %0d", cap_di, cap_ci + 2 * N); else n_pass++;
    endtask

    task automatic test_random();
        int k, kl;
        for (int j = 0; j < 6; j++) begin
            k  = $urandom_range(1, K_MAX + 3);
            kl = (k > K_MAX) ? K_MAX : k;
            vecs.delete();
            for (int i = 0; i < k + 1; i++) vecs.push_back(VW'($urandom));
            run_job(k, 2, -1);
            n_total++;
            if (hs !== kl || cap_nclr !== 1) $display("FAIL rand_hs job=%0d got hs=%0d clears=%0d exp %0d 1", j, hs, cap_nclr, kl); else n_pass++;
            for (int t = 0; t < kl + 2 * N - 2; t++) begin
                n_total++;
                if (cap_lane[cap_ci+1+t] !== model_row(t, kl))
                    $display("FAIL rand_stream job=%0d t=%0d got %h exp %h", j, t, cap_lane[cap_ci+1+t], model_row(t, kl));
                else n_pass++;
            end
            n_total++;
            if (cap_di !== cap_ci + kl + 2 * N - 1) $display("FAIL rand_done job=%0d got %0d exp %0d", j, cap_di, cap_ci + kl + 2 * N - 1); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_overlen();
        test_start_during_stream();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
